// File: rtl/decode_queue.sv
// Instruction buffer (circular FIFO of {ir, pc}) with a combinational MIPS decoder on the head entry.
// Optional macro DECODE_ILLEGAL_EN flags head words that match no supported encoding.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_ir,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [4:0]             out_id,
    output logic                   out_illegal,
    output logic [4:0]             out_rsc,
    output logic [4:0]             out_rtc,
    output logic [4:0]             out_rdc,
    output logic [4:0]             out_shamt,
    output logic [31:0]            out_imm32,
    output logic [25:0]            out_index,
    output logic                   out_rs_used,
    output logic                   out_rt_used,
    output logic                   out_rd_wr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]     ir_mem [DEPTH];
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic [31:0]     head_ir;
    logic [5:0]      op;
    logic [5:0]      fn;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is data only: never reset, occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr] <= in_ir;
            pc_mem[wr_ptr] <= in_pc;
        end
    end

    assign head_ir = ir_mem[rd_ptr];
    assign op      = head_ir[31:26];
    assign fn      = head_ir[5:0];
    assign out_pc  = out_valid ? pc_mem[rd_ptr] : '0;

    always_comb begin
        out_id = 5'd0;
        if (out_valid) begin
            if (op == 6'h00) begin
                case (fn)
                    6'h20: out_id = 5'd1;
                    6'h21: out_id = 5'd2;
                    6'h22: out_id = 5'd3;
                    6'h23: out_id = 5'd4;
                    6'h24: out_id = 5'd5;
                    6'h25: out_id = 5'd6;
                    6'h26: out_id = 5'd7;
                    6'h27: out_id = 5'd8;
                    6'h2A: out_id = 5'd9;
                    6'h2B: out_id = 5'd10;
                    6'h00: out_id = 5'd11;
                    6'h02: out_id = 5'd12;
                    6'h03: out_id = 5'd13;
                    6'h04: out_id = 5'd14;
                    6'h06: out_id = 5'd15;
                    6'h07: out_id = 5'd16;
                    6'h08: out_id = 5'd17;
                    default: out_id = 5'd0;
                endcase
            end else begin
                case (op)
                    6'h08: out_id = 5'd18;
                    6'h09: out_id = 5'd19;
                    6'h0C: out_id = 5'd20;
                    6'h0D: out_id = 5'd21;
                    6'h0E: out_id = 5'd22;
                    6'h23: out_id = 5'd23;
                    6'h2B: out_id = 5'd24;
                    6'h04: out_id = 5'd25;
                    6'h05: out_id = 5'd26;
                    6'h0A: out_id = 5'd27;
                    6'h0B: out_id = 5'd28;
                    6'h0F: out_id = 5'd29;
                    6'h02: out_id = 5'd30;
                    6'h03: out_id = 5'd31;
                    default: out_id = 5'd0;
                endcase
            end
        end
    end

    // Field extraction keys off the decoded id, so unknown or absent heads yield all zeros.
    always_comb begin
        out_rsc     = 5'd0;
        out_rtc     = 5'd0;
        out_rdc     = 5'd0;
        out_shamt   = 5'd0;
        out_imm32   = 32'd0;
        out_index   = 26'd0;
        out_rs_used = 1'b0;
        out_rt_used = 1'b0;
        out_rd_wr   = 1'b0;
        if (out_id >= 5'd1 && out_id <= 5'd17) begin
            if (out_id >= 5'd11 && out_id <= 5'd13) begin
                out_shamt = head_ir[10:6];
            end else begin
                out_rsc     = head_ir[25:21];
                out_rs_used = 1'b1;
            end
            if (out_id != 5'd17) begin
                out_rtc     = head_ir[20:16];
                out_rt_used = 1'b1;
                out_rdc     = head_ir[15:11];
                out_rd_wr   = 1'b1;
            end
        end
        case (out_id)
            5'd18, 5'd19, 5'd23, 5'd27, 5'd28: begin
                out_rsc     = head_ir[25:21];
                out_rs_used = 1'b1;
                out_rdc     = head_ir[20:16];
                out_rd_wr   = 1'b1;
                out_imm32   = {{16{head_ir[15]}}, head_ir[15:0]};
            end
            5'd20, 5'd21, 5'd22: begin
                out_rsc     = head_ir[25:21];
                out_rs_used = 1'b1;
                out_rdc     = head_ir[20:16];
                out_rd_wr   = 1'b1;
                out_imm32   = {16'h0000, head_ir[15:0]};
            end
            5'd24, 5'd25, 5'd26: begin
                out_rsc     = head_ir[25:21];
                out_rs_used = 1'b1;
                out_rtc     = head_ir[20:16];
                out_rt_used = 1'b1;
                out_imm32   = {{16{head_ir[15]}}, head_ir[15:0]};
            end
            5'd29: begin
                out_rdc   = head_ir[20:16];
                out_rd_wr = 1'b1;
                out_imm32 = {head_ir[15:0], 16'h0000};
            end
            5'd30: out_index = head_ir[25:0];
            5'd31: begin
                out_index = head_ir[25:0];
                out_rdc   = 5'd31;
                out_rd_wr = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    assign out_illegal = out_valid && (out_id == 5'd0);
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-buffer entries; power of two, range 2..16.
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the PC carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  producer offers in_ir/in_pc.
REQ-007 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-008 SHALL have ports in_ir  input  32  instruction word; in_pc  input  PC_W  its address.
REQ-009 SHALL have port out_valid  output  1  head entry is present and decoded.
REQ-010 SHALL have port out_ready  input  1  consumer takes the head this cycle.
REQ-011 SHALL have ports out_pc  output  PC_W; out_id  output  5  instruction code; out_illegal  output  1.
REQ-012 SHALL have ports out_rsc/out_rtc/out_rdc  output  5 each; out_shamt  output  5; out_imm32  output  32; out_index  output  26.
REQ-013 SHALL have ports out_rs_used/out_rt_used/out_rd_wr  output  1 each; count  output  $clog2(DEPTH)+1  occupancy.

Function
REQ-014 SHALL be a circular FIFO of {in_ir, in_pc}; push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (count != DEPTH); no pass-through when full, even if a pop occurs the same cycle.
REQ-016 SHALL drive out_valid = (count != 0); a word pushed in cycle N is visible at the outputs in cycle N+1.
REQ-017 SHALL on simultaneous push and pop keep count unchanged and advance both pointers; pointers wrap modulo DEPTH.
REQ-018 SHALL on flush set count, read pointer and write pointer to 0 next edge; flush overrides a same-cycle push and pop.
REQ-019 SHALL decode the head combinationally; out_id: 0 none/illegal; 1-17 add,addu,sub,subu,and,or,xor,nor,slt,sltu,sll,srl,sra,sllv,srlv,srav,jr (op 0, by funct).
REQ-020 SHALL continue out_id: 18-29 addi,addiu,andi,ori,xori,lw,sw,beq,bne,slti,sltiu,lui; 30 j; 31 jal (standard MIPS opcodes).
REQ-021 SHALL drive out_rsc = IR[25:21] with out_rs_used=1 for all R-type except sll/srl/sra, plus addi..sltiu; otherwise out_rsc=0 and out_rs_used=0.
REQ-022 SHALL drive out_rtc = IR[20:16] with out_rt_used=1 for R-type except jr, plus sw/beq/bne; otherwise out_rtc=0 and out_rt_used=0.
REQ-023 SHALL drive out_rdc = IR[15:11] for R-type except jr; IR[20:16] for addi..xori, lw, slti, sltiu, lui; 31 for jal; otherwise 0; out_rd_wr=1 exactly in these cases.
REQ-024 SHALL drive out_shamt = IR[10:6] for sll/srl/sra, else 0; out_index = IR[25:0] for j/jal, else 0.
REQ-025 SHALL drive out_imm32 as zero-extension for andi/ori/xori, {IR[15:0],16'h0} for lui, sign-extension for other I-type, and 0 otherwise.
REQ-026 SHALL force all decoded outputs and out_pc to 0 when out_valid=0.

Reset
REQ-027 SHALL on rst clear count and both pointers, giving in_ready=1, out_valid=0 and all decoded outputs 0, independent of clk.
REQ-028 SHALL treat rst asserted mid-transfer as a discard of all entries; no push or pop completes in that cycle.
REQ-029 SHALL not require reset of the FIFO storage array.

Configuration
REQ-030 SHALL honour macro DECODE_ILLEGAL_EN: when defined, out_illegal=1 with out_id=0 for any head word matching no listed encoding (R-type with funct checked; no other fields checked).
REQ-031 SHALL, without DECODE_ILLEGAL_EN, tie out_illegal to 0, present unknown words as out_id=0 with all decoded fields 0, and synthesise no illegal-detection logic.

Verification
REQ-032 SHALL cover: reset, then push 0x2008FFFF (addi) -> next cycle out_valid=1, out_id=18, out_rsc=0, out_rdc=8, out_imm32=0xFFFFFFFF, out_rd_wr=1.
REQ-033 SHALL cover: DEPTH=4, 5 pushes with out_ready=0 -> count=4 and in_ready=0 after the 4th; the 5th word is never output; 4 pops then return words in order.
REQ-034 SHALL cover: push 0x3421FFFF (ori), 0x3C011234 (lui), 0x0C100000 (jal) -> imm32 0x0000FFFF with id 21; imm32 0x12340000 with id 29; id 31 with out_rdc=31 and out_index=0x0100000.
REQ-035 SHALL cover: count=3 with flush, in_valid=1 and out_ready=1 in the same cycle -> count=0 and out_valid=0 next cycle.
REQ-036 SHALL cover: push 0xFC000000 -> out_illegal=1 and out_id=0 with DECODE_ILLEGAL_EN; out_illegal=0 and out_id=0 without it.
REQ-037 SHALL cover: rst pulsed asynchronously between clock edges while count=2 -> count=0 and out_valid=0 immediately, before the next clk edge.
